// File: rtl/usb_sniff_pkg.sv
// Shared command codes, register map and FSM encoding
// for the SPI command controller.
package usb_sniff_pkg;

    localparam logic [4:0] CMD_STATUS = 5'h00;
    localparam logic [4:0] CMD_STREAM = 5'h10;
    localparam logic [1:0] CMD_REG_HI = 2'b01;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_FILTER = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_ID     = 3'd3;

    localparam logic [7:0] RST_CTRL   = 8'h00;
    localparam logic [7:0] RST_FILTER = 8'hFF;

    localparam int STAT_EMPTY  = 0;
    localparam int STAT_UNDER  = 1;
    localparam int STAT_ILL    = 2;
    localparam int STAT_SPIERR = 3;

    localparam logic [5:0] IDX_MAX = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_REG_WR,
        ST_REG_RD,
        ST_STREAM,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/cfg_regfile.sv
// Config registers, sticky status bits and
// read-to-clear handling.
module cfg_regfile
    import usb_sniff_pkg::*;
#(
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_addr,
    input  logic       rd_clr,
    input  logic       set_under,
    input  logic       set_ill,
    input  logic       set_spierr,
    input  logic       fifo_empty,
    output logic [7:0] rd_data,
    output logic [7:0] cfg_ctrl,
    output logic [7:0] cfg_filter
);

    logic under;
    logic ill;
    logic spierr;

    // A set on the same edge as a status read wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ctrl   <= RST_CTRL;
            cfg_filter <= RST_FILTER;
            under      <= 1'b0;
            ill        <= 1'b0;
            spierr     <= 1'b0;
        end else begin
            if (wr_en && wr_addr == ADDR_CTRL)
                cfg_ctrl <= wr_data;
            if (wr_en && wr_addr == ADDR_FILTER)
                cfg_filter <= wr_data;
            under  <= set_under | (under & ~rd_clr);
            ill    <= set_ill | (ill & ~rd_clr);
            spierr <= set_spierr | (spierr & ~rd_clr);
        end
    end

    always_comb begin
        rd_data = 8'h00;
        unique case (rd_addr)
            ADDR_CTRL:   rd_data = cfg_ctrl;
            ADDR_FILTER: rd_data = cfg_filter;
            ADDR_STATUS: begin
                rd_data[STAT_EMPTY]  = fifo_empty;
                rd_data[STAT_UNDER]  = under;
                rd_data[STAT_ILL]    = ill;
                rd_data[STAT_SPIERR] = spierr;
            end
            ADDR_ID:     rd_data = ID_VALUE;
            default:     rd_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command front end: frame/byte tracking, header
// decode and the registered TX byte mux.
module spi_cmd_ctrl
    import usb_sniff_pkg::*;
#(
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spi_data_rx,
    input  logic       spi_eob,
    input  logic       spi_busy,
    input  logic [4:0] spi_cmd,
    input  logic       spi_read,
    input  logic       spi_err_in,
    output logic [7:0] spi_data_tx,
    output logic       spi_err,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic [7:0] cfg_ctrl,
    output logic [7:0] cfg_filter
);

    state_t     state;
    state_t     hdr_next;
    logic       busy_q;
    logic       eob_q;
    logic       armed;
    logic [5:0] idx;
    logic [2:0] wr_addr;
    logic [2:0] hdr_addr;
    logic       act;
    logic       start;
    logic       hdr_eob;
    logic       stream_eob;
    logic       pop;
    logic       wr_en;
    logic       rd_clr;
    logic       set_ill;
    logic       set_under;
    logic [7:0] rd_data;
    logic [7:0] hdr_tx;
    logic [7:0] stream_tx;

    // armed blocks a frame that was already running
    // when reset released.
    assign act     = spi_eob & ~eob_q & spi_busy;
    assign start   = spi_busy & ~busy_q & armed;
    assign hdr_eob = act & (state == ST_HDR);

    always_comb begin
        hdr_next = ST_DRAIN;
        hdr_addr = spi_cmd[2:0];
        unique case (1'b1)
            (spi_cmd[4:3] == CMD_REG_HI):
                hdr_next = spi_read ? ST_REG_RD : ST_REG_WR;
            (spi_cmd == CMD_STREAM && spi_read):
                hdr_next = ST_STREAM;
            (spi_cmd == CMD_STATUS): begin
                hdr_next = ST_REG_RD;
                hdr_addr = ADDR_STATUS;
            end
            default:
                hdr_next = ST_DRAIN;
        endcase
    end

    assign stream_eob = act & ((state == ST_STREAM) |
                        (hdr_eob & (hdr_next == ST_STREAM)));
    assign pop        = stream_eob & ~fifo_empty;
    assign set_under  = stream_eob & fifo_empty;
    assign set_ill    = hdr_eob & (hdr_next == ST_DRAIN);
    assign rd_clr     = hdr_eob & (hdr_next == ST_REG_RD) &
                        (hdr_addr == ADDR_STATUS);
    assign wr_en      = act & (state == ST_REG_WR) &
                        (idx == 6'd1);
    assign stream_tx  = fifo_empty ? 8'h00 : fifo_data;

    always_comb begin
        hdr_tx = 8'h00;
        unique case (hdr_next)
            ST_REG_RD: hdr_tx = rd_data;
            ST_STREAM: hdr_tx = stream_tx;
            default:   hdr_tx = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= 6'd0;
            wr_addr     <= 3'd0;
            spi_data_tx <= ID_VALUE;
            spi_err     <= 1'b0;
            fifo_rd     <= 1'b0;
            busy_q      <= 1'b0;
            eob_q       <= 1'b0;
            armed       <= 1'b0;
        end else begin
            busy_q  <= spi_busy;
            eob_q   <= spi_eob;
            spi_err <= set_ill;
            fifo_rd <= pop;
            if (!spi_busy) begin
                armed       <= 1'b1;
                state       <= ST_IDLE;
                idx         <= 6'd0;
                spi_data_tx <= ID_VALUE;
            end else begin
                if (act && state != ST_IDLE && idx != IDX_MAX)
                    idx <= idx + 6'd1;
                unique case (state)
                    ST_IDLE: if (start) begin
                        state <= ST_HDR;
                        idx   <= 6'd0;
                    end
                    ST_HDR: if (act) begin
                        state       <= hdr_next;
                        wr_addr     <= hdr_addr;
                        spi_data_tx <= hdr_tx;
                    end
                    ST_STREAM: if (act)
                        spi_data_tx <= stream_tx;
                    default: if (act)
                        spi_data_tx <= 8'h00;
                endcase
            end
        end
    end

    cfg_regfile #(
        .ID_VALUE(ID_VALUE)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (spi_data_rx),
        .rd_addr   (hdr_addr),
        .rd_clr    (rd_clr),
        .set_under (set_under),
        .set_ill   (set_ill),
        .set_spierr(spi_err_in),
        .fifo_empty(fifo_empty),
        .rd_data   (rd_data),
        .cfg_ctrl  (cfg_ctrl),
        .cfg_filter(cfg_filter)
    );

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: frame-level reference model,
// per-cycle compare and directed literal checks.
module tb_spi_cmd_ctrl;

    localparam logic [7:0] ID = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] spi_data_rx;
    logic       spi_eob;
    logic       spi_busy;
    logic [4:0] spi_cmd;
    logic       spi_read;
    logic       spi_err_in;
    logic [7:0] spi_data_tx;
    logic       spi_err;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] cfg_ctrl;
    logic [7:0] cfg_filter;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(.ID_VALUE(ID)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_data_rx(spi_data_rx),
        .spi_eob    (spi_eob),
        .spi_busy   (spi_busy),
        .spi_cmd    (spi_cmd),
        .spi_read   (spi_read),
        .spi_err_in (spi_err_in),
        .spi_data_tx(spi_data_tx),
        .spi_err    (spi_err),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .cfg_ctrl   (cfg_ctrl),
        .cfg_filter (cfg_filter)
    );

    int errors = 0;
    int checks = 0;

    task automatic check8(input string name,
                          input logic [7:0] act,
                          input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef enum int {
        M_IDLE, M_HDR, M_WR, M_RD, M_STREAM, M_DRAIN
    } mode_t;

    mode_t      m_mode;
    logic       m_armed;
    logic       m_busy_q;
    int         m_nb;
    logic [2:0] m_addr;
    logic [7:0] m_ctrl;
    logic [7:0] m_filter;
    logic       m_under;
    logic       m_ill;
    logic       m_spierr;
    logic [7:0] fq[$];

    logic [7:0] exp_tx;
    logic       exp_txk;
    logic       exp_rd;
    logic       exp_err;
    logic [7:0] exp_ctrl;
    logic [7:0] exp_filter;
    logic       pend_apply;
    logic       pend_pop;
    logic [7:0] n_tx;
    logic       n_txk;
    logic       n_rd;
    logic       n_err;
    logic       chk_en = 1'b0;
    logic       rnd_err = 1'b0;
    logic       force_err = 1'b0;

    int         rd_pulses = 0;
    int         err_pulses = 0;
    logic [7:0] last_tx;
    logic [7:0] tx_log[$];

    function automatic logic [7:0] status_val();
        return {4'b0, m_spierr, m_ill, m_under, fq.size() == 0};
    endfunction

    function automatic logic [7:0] reg_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_ctrl;
            3'd1:    return m_filter;
            3'd2:    return status_val();
            3'd3:    return ID;
            default: return 8'h00;
        endcase
    endfunction

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 8'hEE : fq[0];
    endtask

    task automatic clear_sticky();
        m_under  = 1'b0;
        m_ill    = 1'b0;
        m_spierr = 1'b0;
    endtask

    task automatic stream_step();
        if (fq.size() > 0) begin
            n_tx = fq[0];
            n_rd = 1'b1;
        end else begin
            n_tx    = 8'h00;
            m_under = 1'b1;
        end
    endtask

    // Effect of an EoB edge sampled at the coming clock edge.
    task automatic model_eob();
        logic [2:0] a;
        if (rst || !spi_busy || m_mode == M_IDLE) return;
        n_tx = 8'h00; n_txk = 1'b1;
        n_rd = 1'b0;  n_err = 1'b0;
        pend_apply = 1'b1;
        case (m_mode)
            M_HDR: begin
                a = spi_cmd[2:0];
                if (spi_cmd >= 5'd8 && spi_cmd <= 5'd15) begin
                    if (spi_read) begin
                        m_mode = M_RD;
                        n_tx = reg_read(a);
                        if (a == 3'd2) clear_sticky();
                    end else begin
                        m_mode = M_WR;
                        m_addr = a;
                        n_txk  = 1'b0;
                    end
                end else if (spi_cmd == 5'd16 && spi_read) begin
                    m_mode = M_STREAM;
                    stream_step();
                end else if (spi_cmd == 5'd0) begin
                    m_mode = M_RD;
                    n_tx = status_val();
                    clear_sticky();
                end else begin
                    m_mode = M_DRAIN;
                    n_err  = 1'b1;
                    m_ill  = 1'b1;
                end
            end
            M_WR: begin
                n_txk = 1'b0;
                if (m_nb == 1 && m_addr == 3'd0) m_ctrl = spi_data_rx;
                if (m_nb == 1 && m_addr == 3'd1) m_filter = spi_data_rx;
            end
            M_STREAM: stream_step();
            default: ;
        endcase
        m_nb++;
    endtask

    task automatic tick();
        logic s_rst, s_busy, s_err;
        s_rst  = rst;
        s_busy = spi_busy;
        s_err  = spi_err_in;
        @(posedge clk);
        #1;
        exp_rd  = 1'b0;
        exp_err = 1'b0;
        if (pend_pop) begin
            fq.delete(0);
            pend_pop = 1'b0;
        end
        if (pend_apply) begin
            exp_tx  = n_tx;  exp_txk = n_txk;
            exp_rd  = n_rd;  exp_err = n_err;
            pend_pop   = n_rd;
            pend_apply = 1'b0;
        end
        if (s_rst) begin
            m_mode = M_IDLE; m_armed = 1'b0; m_nb = 0;
            m_ctrl = 8'h00;  m_filter = 8'hFF;
            clear_sticky();
            exp_tx = ID; exp_txk = 1'b1;
            exp_rd = 1'b0; exp_err = 1'b0;
        end else begin
            if (s_err) m_spierr = 1'b1;
            if (!s_busy) begin
                m_mode = M_IDLE; m_nb = 0; m_armed = 1'b1;
                exp_tx = ID; exp_txk = 1'b1;
            end else if (m_mode == M_IDLE && m_armed && !m_busy_q) begin
                m_mode = M_HDR;
                m_nb = 0;
            end
        end
        m_busy_q   = s_rst ? 1'b0 : s_busy;
        exp_ctrl   = m_ctrl;
        exp_filter = m_filter;
        refresh();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_txk) check8("tx", spi_data_tx, exp_tx);
            check8("fifo_rd", {7'b0, fifo_rd}, {7'b0, exp_rd});
            check8("spi_err", {7'b0, spi_err}, {7'b0, exp_err});
            check8("cfg_ctrl", cfg_ctrl, exp_ctrl);
            check8("cfg_filter", cfg_filter, exp_filter);
            if (fifo_rd) rd_pulses++;
            if (spi_err) err_pulses++;
        end
    end

    task automatic send_byte(input logic [7:0] rx, input int hold);
        spi_data_rx = rx;
        spi_eob     = 1'b1;
        spi_err_in  = force_err | (rnd_err && $urandom_range(0, 5) == 0);
        model_eob();
        tick();
        last_tx = spi_data_tx;
        tx_log.push_back(last_tx);
        spi_err_in = 1'b0;
        for (int i = 1; i < hold; i++) tick();
        spi_eob = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame(input logic [7:0] hdr, input int nb,
                         input logic [7:0] b1, input int hold);
        tx_log.delete();
        spi_busy = 1'b1;
        tick();
        tick();
        spi_cmd  = hdr[4:0];
        spi_read = hdr[6];
        send_byte(hdr, hold);
        for (int i = 0; i < nb; i++)
            send_byte(i == 0 ? b1 : 8'(b1 + 8'(i)), hold);
        spi_busy = 1'b0;
        tick();
        tick();
    endtask

    int r0;

    initial begin
        rst = 1'b1; spi_busy = 1'b0; spi_eob = 1'b0;
        spi_data_rx = 8'h00; spi_cmd = 5'h00; spi_read = 1'b0;
        spi_err_in = 1'b0;
        pend_apply = 1'b0; pend_pop = 1'b0;
        m_busy_q = 1'b0; m_armed = 1'b0; m_mode = M_IDLE;
        refresh();
        tick();
        chk_en = 1'b1;
        tick();
        check8("rst_tx", spi_data_tx, 8'hA5);
        check8("rst_ctrl", cfg_ctrl, 8'h00);
        check8("rst_filter", cfg_filter, 8'hFF);
        rst = 1'b0;
        tick();
        tick();

        // Write FILTER then read it back.
        frame(8'h09, 1, 8'h3C, 1);
        check8("wr_filter", cfg_filter, 8'h3C);
        frame(8'h49, 1, 8'h00, 1);
        check8("rd_filter_tx", tx_log[0], 8'h3C);

        // Stream two bytes then underrun.
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        refresh();
        r0 = rd_pulses;
        frame(8'h50, 3, 8'h00, 1);
        check8("stream_b0", tx_log[0], 8'h11);
        check8("stream_b1", tx_log[1], 8'h22);
        check8("stream_b2", tx_log[2], 8'h00);
        check8("stream_pops", 8'(rd_pulses - r0), 8'd2);
        frame(8'h40, 1, 8'h00, 1);
        check8("status_under", tx_log[0], 8'h03);

        // Illegal header.
        r0 = err_pulses;
        frame(8'h1F, 1, 8'h00, 1);
        check8("ill_pulses", 8'(err_pulses - r0), 8'd1);
        check8("ill_tx", tx_log[0], 8'h00);
        frame(8'h40, 1, 8'h00, 1);
        check8("ill_set", tx_log[0], 8'h05);
        frame(8'h40, 1, 8'h00, 1);
        check8("ill_clear", tx_log[0], 8'h01);

        // Reset during byte 1 of a CTRL write.
        spi_busy = 1'b1;
        tick();
        tick();
        spi_cmd = 5'h08;
        spi_read = 1'b0;
        send_byte(8'h08, 1);
        rst = 1'b1;
        send_byte(8'h5A, 1);
        rst = 1'b0;
        send_byte(8'h77, 1);
        send_byte(8'h66, 1);
        spi_busy = 1'b0;
        tick();
        tick();
        check8("rst_mid_ctrl", cfg_ctrl, 8'h00);

        // Long EoB pulses.
        fq.push_back(8'h33);
        fq.push_back(8'h44);
        refresh();
        r0 = rd_pulses;
        frame(8'h50, 1, 8'h00, 3);
        check8("hold_pops", 8'(rd_pulses - r0), 8'd2);
        check8("hold_b1", tx_log[1], 8'h44);
        frame(8'h09, 2, 8'h5C, 3);
        check8("hold_wr", cfg_filter, 8'h5C);

        // Write to read-only ID.
        r0 = err_pulses;
        frame(8'h0B, 1, 8'hFF, 1);
        check8("ro_no_err", 8'(err_pulses - r0), 8'd0);
        frame(8'h4B, 1, 8'h00, 1);
        check8("ro_id", tx_log[0], 8'hA5);

        // SPIERR set coincides with status read-clear.
        force_err = 1'b1;
        frame(8'h40, 0, 8'h00, 1);
        force_err = 1'b0;
        frame(8'h40, 0, 8'h00, 1);
        check8("set_wins", tx_log[0], 8'h09);
        frame(8'h40, 0, 8'h00, 1);
        check8("spierr_clr", tx_log[0], 8'h01);

        // Byte index saturates instead of wrapping to 1.
        frame(8'h08, 66, 8'h12, 1);
        check8("sat_ctrl", cfg_ctrl, 8'h12);

        rnd_err = 1'b1;
        for (int f = 0; f < 80; f++) begin
            logic [4:0] c;
            int sel, n;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++)
                if (fq.size() < 8) fq.push_back(8'($urandom));
            refresh();
            sel = $urandom_range(0, 3);
            case (sel)
                0:       c = 5'h00;
                1:       c = 5'(8 + $urandom_range(0, 7));
                2:       c = 5'h10;
                default: c = 5'($urandom);
            endcase
            frame({1'b0, 1'($urandom), 1'b0, c},
                  $urandom_range(0, 4), 8'($urandom),
                  $urandom_range(1, 3));
        end
        rnd_err = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter ID_VALUE, default 8'hA5: constant returned by the ID register and shifted out during every header byte.
REQ-002 SHALL have ports, in this order:
- clk  in  1  master clock.
- rst  in  1  reset, synchronous, active-high.
- spi_data_rx  in  8  last received byte from SPI_COMM DATA_out.
- spi_eob  in  1  end-of-byte strobe from SPI_COMM EoB; may be high for more than one cycle.
- spi_busy  in  1  SPI_COMM busy; high for the whole frame.
- spi_cmd  in  5  header command field.
- spi_read  in  1  header read flag.
- spi_err_in  in  1  SPI_COMM err_out.
- spi_data_tx  out  8  next byte to send, drives SPI_COMM DATA_in.
- spi_err  out  1  one-cycle illegal-command pulse, drives SPI_COMM err_in.
- fifo_data  in  8  capture FIFO head, first-word-fall-through.
- fifo_empty  in  1  capture FIFO empty.
- fifo_rd  out  1  one-cycle FIFO pop.
- cfg_ctrl  out  8  register 0.
- cfg_filter  out  8  register 1.

Function
REQ-003 SHALL detect frame start on the rising edge of spi_busy, using a registered copy; a frame already in progress when IDLE is entered SHALL be ignored.
REQ-004 SHALL act on each spi_eob rising edge only, and count these edges in a 6-bit byte index; index 0 is the header, and the count saturates at 63.
REQ-005 SHALL implement FSM states IDLE, HDR, REG_WR, REG_RD, STREAM and DRAIN, with these transitions:
- IDLE->HDR on frame start.
- HDR->(REG_WR | REG_RD | STREAM | DRAIN) on the header EoB, selected by decode.
- Any state->IDLE on the cycle spi_busy is sampled low.
REQ-006 SHALL decode the header on its EoB as follows:
- spi_cmd 5'h08-5'h0F: register access, address spi_cmd[2:0]; spi_read=1 goes to REG_RD, spi_read=0 goes to REG_WR.
- spi_cmd 5'h10 with spi_read=1: STREAM.
- spi_cmd 5'h00: REG_RD at address 2 (status).
- All other combinations: DRAIN, a single spi_err pulse, and set sticky bit ILL.
REQ-007 spi_data_tx SHALL be registered and SHALL update only on the clk edge at which a qualifying EoB edge is sampled; it SHALL hold otherwise, so it is stable two cycles later when SPI_COMM loads it.
REQ-008 In IDLE and HDR, spi_data_tx SHALL equal ID_VALUE.
REQ-009 REG_RD SHALL load the addressed register on the header EoB; on later EoBs it SHALL load 8'h00.
REQ-010 REG_WR SHALL write spi_data_rx to the addressed register on the byte-1 EoB; later bytes SHALL be ignored.
REQ-011 The register map SHALL be:
- 0 CTRL: rw, reset 8'h00.
- 1 FILTER: rw, reset 8'hFF.
- 2 STATUS: ro, bits {4'b0, SPIERR, ILL, UNDER, fifo_empty}.
- 3 ID: ro, reads ID_VALUE.
- 4-7: read 8'h00.
REQ-012 Writes to read-only or unused addresses SHALL be ignored without error.
REQ-013 Reading STATUS SHALL clear UNDER, ILL and SPIERR on the same edge the value is loaded into spi_data_tx.
REQ-014 If a set event and a clear fall on the same edge, the set SHALL win.
REQ-015 STREAM SHALL behave as follows on each EoB, starting with the header EoB:
- FIFO not empty: load fifo_data and pulse fifo_rd high for exactly the next cycle.
- FIFO empty: load 8'h00, set UNDER, and leave fifo_rd low.
REQ-016 A byte popped but never shifted out because the frame ended SHALL be discarded, not restored.
REQ-017 In DRAIN, spi_data_tx SHALL be 8'h00, no register writes SHALL occur, and fifo_rd SHALL stay low.
REQ-018 spi_err_in sampled high SHALL set SPIERR.

Reset
REQ-019 On rst, the block SHALL reset to:
- FSM IDLE.
- Byte index 0.
- spi_data_tx ID_VALUE.
- spi_err 0, fifo_rd 0.
- cfg_ctrl 8'h00, cfg_filter 8'hFF.
- Sticky bits 0.
- Registered copies of spi_busy and spi_eob 0.
REQ-020 A reset asserted mid-frame SHALL abort the frame; the block SHALL stay IDLE until the next spi_busy rising edge.

Structure
REQ-021 Package usb_sniff_pkg SHALL hold:
- Command codes.
- Register addresses.
- Register reset values.
- STATUS bit positions.
- FSM state encoding.
REQ-022 The register bank, sticky bits and read-clear logic SHALL be the sub-module cfg_regfile; spi_cmd_ctrl holds the FSM, edge detection and TX mux.

Verification
REQ-023 Write then read: frame 8'h09,8'h3C, then frame 8'h49,x -> cfg_filter=8'h3C; the second frame's byte 1 tx is 8'h3C.
REQ-024 Stream: FIFO holds 8'h11,8'h22; frame 8'h50 followed by 3 bytes -> tx 8'h11, 8'h22, 8'h00; fifo_rd pulses 2 times; the next status read returns 8'h03 when the FIFO is empty.
REQ-025 Illegal command: header 8'h1F -> one spi_err pulse, tx 8'h00; the next status read returns ILL set, and the read after that returns ILL clear.
REQ-026 Reset mid-frame: rst during byte 1 of a write to CTRL -> cfg_ctrl stays 8'h00, and no write occurs when the remaining EoBs arrive.
REQ-027 Multi-cycle EoB: spi_eob held 3 cycles -> byte index advances by 1, and fifo_rd pulses once.
REQ-028 RO write: frame 8'h0B,8'hFF -> ID still reads 8'hA5, and no spi_err pulse.
